// File: rtl/ps2_key_event_tx_if.sv
// ps2_key_event_tx_if: signal bundle between a key-level source and the
// ps2_key event encoder.
//   key_state [NKEYS]   : current level per key, 1 = held
//   key_codes [9*NKEYS] : static scan code per key, key i at [9*i+8 : 9*i]
//   ps2_key   [11]      : event word {toggle, pressed, ext, code[7:0]}
//   busy                : events queued or output spacing still running
// master = stimulus side, slave = encoder side.
interface ps2_key_event_tx_if #(
    parameter int unsigned NKEYS = 8
);
    logic [NKEYS-1:0]   key_state;
    logic [9*NKEYS-1:0] key_codes;
    logic [10:0]        ps2_key;
    logic               busy;

    modport master (
        output key_state,
        output key_codes,
        input  ps2_key,
        input  busy
    );

    modport slave (
        input  key_state,
        input  key_codes,
        output ps2_key,
        output busy
    );
endinterface

// File: rtl/ps2_key_event_tx.sv
// ps2_key_event_tx: turns level changes on a vector of keys into press /
// release events on the 11-bit toggle-style ps2_key word.
//   clk_sys   : single clock
//   reset     : synchronous, active-high; clears reported state and queue
//   bus.slave : key_state / key_codes in, ps2_key / busy out
// A scanner pushes at most one changed key per cycle (lowest index first)
// into a circular FIFO; an output FSM pops one entry, flips ps2_key[10],
// and then holds for GAP edges before the next emit is allowed.
module ps2_key_event_tx #(
    parameter int unsigned NKEYS = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned GAP   = 4
) (
    input logic               clk_sys,
    input logic               reset,
    ps2_key_event_tx_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = $clog2(GAP + 1);
    localparam int unsigned IW = (NKEYS > 1) ? $clog2(NKEYS) : 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [10:0]       ps2_q, ps2_d;

    logic [NKEYS-1:0]  prev_q;
    logic [NKEYS-1:0]  changed;
    logic              sel_valid;
    logic [IW-1:0]     sel_idx;
    logic              sel_level;
    logic [8:0]        sel_code;

    logic [9:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop;

    assign changed = bus.key_state ^ prev_q;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    // Lowest-index changed key wins; the first hit is latched by sel_valid.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_level = 1'b0;
        sel_code  = '0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (!sel_valid && changed[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(i);
                sel_level = bus.key_state[i];
                sel_code  = bus.key_codes[9*i +: 9];
            end
        end
    end

    // Full flag is the start-of-cycle one: a same-cycle pop never frees a
    // slot for this edge's push, so prev simply lags until space exists.
    assign push = sel_valid && !full;
    assign pop  = (state_q == IDLE) && !empty;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr]     <= {sel_level, sel_code};
                wr_ptr          <= wr_ptr + AW'(1);
                prev_q[sel_idx] <= sel_level;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        ps2_d   = ps2_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    ps2_d   = {~ps2_q[10], mem[rd_ptr]};
                    gcnt_d  = GW'(GAP - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                gcnt_d = gcnt_q - GW'(1);
                if (gcnt_q == GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            ps2_q   <= '0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            ps2_q   <= ps2_d;
        end
    end

    assign bus.ps2_key = ps2_q;
    assign bus.busy    = !empty || (state_q != IDLE);
endmodule
